// File: rtl/program_loader.sv
// Program memory loader: unpacks a framed byte stream (SYNC, LEN, data pairs, CHK)
// into 16-bit instruction writes and holds the CPU in reset until the frame checks out.
module program_loader #(
    parameter int          DEPTH     = 256,
    parameter int          TIMEOUT   = 1000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        pm_we,
    output logic [15:0] pm_addr,
    output logic [15:0] pm_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    localparam logic [16:0] DEPTH_W      = 17'(DEPTH);
    localparam logic        TIMEOUT_EN   = (TIMEOUT > 32'sd0);
    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT > 32'sd0) ? 32'(TIMEOUT - 32'sd1) : 32'd0;

    // States that are inside a frame: the idle timer runs only here.
    function automatic logic in_frame(input state_t st);
        logic r;
        case (st)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: r = 1'b1;
            default:                                               r = 1'b0;
        endcase
        return r;
    endfunction

    // Running checksum over data bytes only.
    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t       state_r;
    state_t       state_nxt_s;
    logic [7:0]   len_hi_r;
    logic [15:0]  len_r;
    logic [7:0]   hi_r;
    logic [7:0]   checksum_r;
    logic [31:0]  timer_r;
    logic [15:0]  words_r;
    logic         pm_we_r;
    logic [15:0]  pm_addr_r;
    logic [15:0]  pm_wdata_r;
    logic         in_ready_r;
    logic         cpu_hold_r;
    logic         done_r;
    logic         error_r;

    logic         xfer_s;
    logic         timeout_s;
    logic         len_over_s;
    logic         len_zero_s;
    logic         last_word_s;

    assign xfer_s      = in_valid & in_ready_r;
    assign timeout_s   = TIMEOUT_EN && in_frame(state_r) && !xfer_s && (timer_r == TIMEOUT_LAST);
    assign len_over_s  = {1'b0, len_hi_r, in_data} > DEPTH_W;
    assign len_zero_s  = ({len_hi_r, in_data} == 16'd0);
    assign last_word_s = ((words_r + 16'd1) == len_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a byte arriving on the timeout cycle takes priority.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s && (in_data == SYNC_BYTE)) state_nxt_s = ST_LEN_HI;
                else                                  state_nxt_s = ST_IDLE;
            end
            ST_LEN_HI: begin
                if (xfer_s)         state_nxt_s = ST_LEN_LO;
                else if (timeout_s) state_nxt_s = ST_ERROR;
                else                state_nxt_s = ST_LEN_HI;
            end
            ST_LEN_LO: begin
                if (xfer_s) begin
                    if (len_over_s)      state_nxt_s = ST_ERROR;
                    else if (len_zero_s) state_nxt_s = ST_CHECK;
                    else                 state_nxt_s = ST_DATA_HI;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_LEN_LO;
                end
            end
            ST_DATA_HI: begin
                if (xfer_s)         state_nxt_s = ST_DATA_LO;
                else if (timeout_s) state_nxt_s = ST_ERROR;
                else                state_nxt_s = ST_DATA_HI;
            end
            ST_DATA_LO: begin
                if (xfer_s) begin
                    if (last_word_s) state_nxt_s = ST_CHECK;
                    else             state_nxt_s = ST_DATA_HI;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_DATA_LO;
                end
            end
            ST_CHECK: begin
                if (xfer_s) begin
                    if (in_data == checksum_r) state_nxt_s = ST_DONE;
                    else                       state_nxt_s = ST_ERROR;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_DONE: begin
                if (reload) state_nxt_s = ST_IDLE;
                else        state_nxt_s = ST_DONE;
            end
            ST_ERROR: begin
                if (reload) state_nxt_s = ST_IDLE;
                else        state_nxt_s = ST_ERROR;
            end
            default: state_nxt_s = ST_ERROR;
        endcase
    end

    // Status outputs are registered from the next state so they track it without lag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_ready_r <= 1'b1;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            in_ready_r <= (state_nxt_s == ST_IDLE) || in_frame(state_nxt_s);
            cpu_hold_r <= (state_nxt_s != ST_DONE);
            done_r     <= (state_nxt_s == ST_DONE);
            error_r    <= (state_nxt_s == ST_ERROR);
        end
    end

    // Inter-byte idle timer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_r <= 32'd0;
        end else if (xfer_s || !in_frame(state_r) || !TIMEOUT_EN) begin
            timer_r <= 32'd0;
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // Length capture, word packing, checksum and the memory write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_hi_r   <= 8'd0;
            len_r      <= 16'd0;
            hi_r       <= 8'd0;
            checksum_r <= 8'd0;
            words_r    <= 16'd0;
            pm_we_r    <= 1'b0;
            pm_addr_r  <= 16'd0;
            pm_wdata_r <= 16'd0;
        end else begin
            pm_we_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s && (in_data == SYNC_BYTE)) begin
                        checksum_r <= 8'd0;
                        words_r    <= 16'd0;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer_s) len_hi_r <= in_data;
                end
                ST_LEN_LO: begin
                    if (xfer_s) len_r <= {len_hi_r, in_data};
                end
                ST_DATA_HI: begin
                    if (xfer_s) begin
                        hi_r       <= in_data;
                        checksum_r <= chk_update(checksum_r, in_data);
                    end
                end
                ST_DATA_LO: begin
                    // The write overlaps acceptance of the next HI byte.
                    if (xfer_s) begin
                        checksum_r <= chk_update(checksum_r, in_data);
                        pm_we_r    <= 1'b1;
                        pm_addr_r  <= words_r;
                        pm_wdata_r <= {hi_r, in_data};
                        words_r    <= words_r + 16'd1;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (reload) begin
                        checksum_r <= 8'd0;
                        words_r    <= 16'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign pm_we        = pm_we_r;
    assign pm_addr      = pm_addr_r;
    assign pm_wdata     = pm_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_r;

endmodule
